// File: rtl/piton_core_wakeup_ctrl.sv
// piton_core_wakeup_ctrl: per-tile core wakeup/park sequencer.
// Waits an SRAM-init interval after reset. It then decodes L1.5 interrupt
// return packets to wake and park harts. It gates each hart's L1.5 request
// valid and drives per-hart core resets. It also synchronises each hart's
// asynchronous interrupt lines.
// Optional build macro: WAKEUP_OVERRIDE_EN adds wakeup_override_i, which
// forces harts out of SLEEP/INIT into RUN without a WAKE packet.
module piton_core_wakeup_ctrl #(
  parameter int unsigned NUM_HARTS   = 1,
  parameter int unsigned HART_ID_W   = 5,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned IRQ_WIDTH   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_l,
  input  logic                           rtrn_val_i,
  input  logic                           rtrn_is_int_i,
  input  logic [63:0]                    rtrn_data_i,
  input  logic [NUM_HARTS-1:0]           req_val_i,
  input  logic [NUM_HARTS-1:0]           req_ack_i,
`ifdef WAKEUP_OVERRIDE_EN
  input  logic [NUM_HARTS-1:0]           wakeup_override_i,
`endif
  output logic [NUM_HARTS-1:0]           req_val_o,
  output logic [NUM_HARTS-1:0]           core_rst_no,
  input  logic [NUM_HARTS*IRQ_WIDTH-1:0] irq_async_i,
  output logic [NUM_HARTS*IRQ_WIDTH-1:0] irq_sync_o,
  output logic [NUM_HARTS*2-1:0]         hart_state_o,
  output logic                           init_done_o
);

  localparam logic [1:0] S_INIT  = 2'b00;
  localparam logic [1:0] S_SLEEP = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_DRAIN = 2'b11;

  // ---------------------------------------------------------------------
  // Init-wait counter
  // ---------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 cnt_msb;

  assign cnt_msb = cnt_q[CNT_WIDTH-1];

  // Count up after reset; hold once the MSB is set.
  always_comb begin
    cnt_d = cnt_q;
    if (!cnt_msb) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!reset_l) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign init_done_o = cnt_msb;

  // ---------------------------------------------------------------------
  // Interrupt packet decode (shared by all harts)
  // ---------------------------------------------------------------------
  logic                 int_val;
  logic                 is_wake;
  logic                 is_park;
  logic [HART_ID_W-1:0] hart_sel;
  logic                 sel_bcast;
  logic                 unused_data;

  assign int_val     = rtrn_val_i & rtrn_is_int_i;
  assign is_wake     = int_val & (rtrn_data_i[17:16] == 2'b01) & (rtrn_data_i[5:0] == 6'b000001);
  assign is_park     = int_val & (rtrn_data_i[17:16] == 2'b11);
  assign hart_sel    = rtrn_data_i[8 +: HART_ID_W];
  assign sel_bcast   = (hart_sel == '1);
  assign unused_data = ^rtrn_data_i;

  // ---------------------------------------------------------------------
  // Per-hart sequencer
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    logic [1:0] st_q, st_d;
    logic       pend_q, pend_d;
    logic       infl_q;
    logic       started_q;
    logic       hit, wake, park, ovr;
    logic       rv_o;

    assign hit  = (hart_sel == HART_ID_W'(g)) | sel_bcast;
    assign wake = is_wake & hit;
    assign park = is_park & hit;
`ifdef WAKEUP_OVERRIDE_EN
    assign ovr  = wakeup_override_i[g];
`else
    assign ovr  = 1'b0;
`endif

    // Request gating: DRAIN only lets an already-presented request stay up.
    always_comb begin
      rv_o = 1'b0;
      case (st_q)
        S_RUN:   rv_o = req_val_i[g];
        S_DRAIN: rv_o = req_val_i[g] & infl_q;
        default: rv_o = 1'b0;
      endcase
    end

    // Next-state and pending-wake logic.
    always_comb begin
      st_d   = st_q;
      pend_d = pend_q;
      case (st_q)
        S_INIT: begin
          if (wake)      pend_d = 1'b1;
          else if (park) pend_d = 1'b0;
          if (cnt_msb)   st_d = (pend_d | ovr) ? S_RUN : S_SLEEP;
        end
        S_SLEEP: begin
          if (wake | ovr) st_d = S_RUN;
        end
        S_RUN: begin
          if (park) st_d = (infl_q | (req_val_i[g] & ~req_ack_i[g])) ? S_DRAIN : S_SLEEP;
        end
        S_DRAIN: begin
          // Leave once nothing is held or the held request is acked.
          if (wake)                       st_d = S_RUN;
          else if (~rv_o | req_ack_i[g])  st_d = S_SLEEP;
        end
        default: st_d = S_INIT;
      endcase
    end

    // Per-hart state, in-flight tracking and core-reset release.
    always_ff @(posedge clk_i) begin
      if (!reset_l) begin
        st_q      <= S_INIT;
        pend_q    <= 1'b0;
        infl_q    <= 1'b0;
        started_q <= 1'b0;
      end else begin
        st_q      <= st_d;
        pend_q    <= pend_d;
        infl_q    <= rv_o & ~req_ack_i[g];
        started_q <= started_q | (st_q == S_RUN);
      end
    end

    assign req_val_o[g]           = rv_o;
    assign core_rst_no[g]         = started_q;
    assign hart_state_o[2*g +: 2] = st_q;
  end

  // ---------------------------------------------------------------------
  // Interrupt synchronisers
  // ---------------------------------------------------------------------
  logic [NUM_HARTS*IRQ_WIDTH-1:0] sync_q [SYNC_STAGES];

  // Plain flop chain; the last stage is the synchronised output.
  always_ff @(posedge clk_i) begin
    if (!reset_l) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq_async_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign irq_sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_piton_core_wakeup_ctrl.sv
// Directed testbench for piton_core_wakeup_ctrl (NUM_HARTS=2, CNT_WIDTH=4).
module tb_piton_core_wakeup_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_l;
  logic        rtrn_val_i;
  logic        rtrn_is_int_i;
  logic [63:0] rtrn_data_i;
  logic [1:0]  req_val_i;
  logic [1:0]  req_ack_i;
  logic [1:0]  req_val_o;
  logic [1:0]  core_rst_no;
  logic [7:0]  irq_async_i;
  logic [7:0]  irq_sync_o;
  logic [3:0]  hart_state_o;
  logic        init_done_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  piton_core_wakeup_ctrl #(
    .NUM_HARTS(2), .HART_ID_W(5), .CNT_WIDTH(4), .IRQ_WIDTH(4), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk_i), .reset_l(reset_l),
    .rtrn_val_i(rtrn_val_i), .rtrn_is_int_i(rtrn_is_int_i), .rtrn_data_i(rtrn_data_i),
    .req_val_i(req_val_i), .req_ack_i(req_ack_i),
    .req_val_o(req_val_o), .core_rst_no(core_rst_no),
    .irq_async_i(irq_async_i), .irq_sync_o(irq_sync_o),
    .hart_state_o(hart_state_o), .init_done_o(init_done_o)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_pkt(input logic [63:0] d);
    rtrn_val_i = 1'b1; rtrn_is_int_i = 1'b1; rtrn_data_i = d;
    tick();
    rtrn_val_i = 1'b0; rtrn_is_int_i = 1'b0; rtrn_data_i = '0;
  endtask

  task automatic test_reset;
    reset_l = 1'b0; rtrn_val_i = 1'b0; rtrn_is_int_i = 1'b0; rtrn_data_i = '0;
    req_val_i = 2'b11; req_ack_i = 2'b00; irq_async_i = '0;
    tick(); tick();
    n_tests++; if (hart_state_o !== 4'b0000) begin n_fail++; $display("FAIL reset_state got %b exp 0000", hart_state_o); end
    n_tests++; if (req_val_o !== 2'b00) begin n_fail++; $display("FAIL reset_req_val got %b exp 00", req_val_o); end
    n_tests++; if (core_rst_no !== 2'b00) begin n_fail++; $display("FAIL reset_core_rst got %b exp 00", core_rst_no); end
    n_tests++; if (init_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got %b exp 0", init_done_o); end
    n_tests++; if (irq_sync_o !== 8'h00) begin n_fail++; $display("FAIL reset_irq got %h exp 00", irq_sync_o); end
  endtask

  task automatic test_init_sleep;
    reset_l = 1'b1;
    repeat (7) tick();
    n_tests++; if (init_done_o !== 1'b0) begin n_fail++; $display("FAIL init_done_c7 got %b exp 0", init_done_o); end
    tick();
    n_tests++; if (init_done_o !== 1'b1) begin n_fail++; $display("FAIL init_done_c8 got %b exp 1", init_done_o); end
    n_tests++; if (hart_state_o !== 4'b0000) begin n_fail++; $display("FAIL state_c8 got %b exp 0000", hart_state_o); end
    tick();
    n_tests++; if (hart_state_o !== 4'b0101) begin n_fail++; $display("FAIL state_sleep got %b exp 0101", hart_state_o); end
    n_tests++; if (req_val_o !== 2'b00) begin n_fail++; $display("FAIL sleep_req_val got %b exp 00", req_val_o); end
    n_tests++; if (core_rst_no !== 2'b00) begin n_fail++; $display("FAIL sleep_core_rst got %b exp 00", core_rst_no); end
    n_tests++; if (init_done_o !== 1'b1) begin n_fail++; $display("FAIL init_done_hold got %b exp 1", init_done_o); end
    // WAKE to hart 3 (>= NUM_HARTS, not broadcast) is ignored
    send_pkt(64'h0000_0000_0001_0301);
    n_tests++; if (hart_state_o !== 4'b0101) begin n_fail++; $display("FAIL ignored_id got %b exp 0101", hart_state_o); end
    req_val_i = 2'b00;
  endtask

  task automatic test_wake_hart1;
    send_pkt(64'h0000_0000_0001_0101);
    n_tests++; if (hart_state_o !== 4'b1001) begin n_fail++; $display("FAIL wake1_state got %b exp 1001", hart_state_o); end
    n_tests++; if (core_rst_no !== 2'b00) begin n_fail++; $display("FAIL wake1_rst_early got %b exp 00", core_rst_no); end
    tick();
    n_tests++; if (core_rst_no !== 2'b10) begin n_fail++; $display("FAIL wake1_rst got %b exp 10", core_rst_no); end
    req_val_i = 2'b11; #1;
    n_tests++; if (req_val_o !== 2'b10) begin n_fail++; $display("FAIL wake1_gate_on got %b exp 10", req_val_o); end
    req_val_i = 2'b00; #1;
    n_tests++; if (req_val_o !== 2'b00) begin n_fail++; $display("FAIL wake1_gate_off got %b exp 00", req_val_o); end
  endtask

  task automatic test_park_drain;
    send_pkt(64'h0000_0000_0001_0001);
    n_tests++; if (hart_state_o !== 4'b1010) begin n_fail++; $display("FAIL wake0_state got %b exp 1010", hart_state_o); end
    tick();
    req_val_i = 2'b01; req_ack_i = 2'b00;
    send_pkt(64'h0000_0000_0003_0000);
    n_tests++; if (hart_state_o !== 4'b1011) begin n_fail++; $display("FAIL park_drain_state got %b exp 1011", hart_state_o); end
    n_tests++; if (req_val_o[0] !== 1'b1) begin n_fail++; $display("FAIL drain_hold got %b exp 1", req_val_o[0]); end
    tick();
    n_tests++; if (hart_state_o !== 4'b1011) begin n_fail++; $display("FAIL drain_wait got %b exp 1011", hart_state_o); end
    n_tests++; if (req_val_o[0] !== 1'b1) begin n_fail++; $display("FAIL drain_hold2 got %b exp 1", req_val_o[0]); end
    req_ack_i = 2'b01;
    tick();
    req_ack_i = 2'b00; #1;
    n_tests++; if (hart_state_o !== 4'b1001) begin n_fail++; $display("FAIL drain_to_sleep got %b exp 1001", hart_state_o); end
    n_tests++; if (req_val_o[0] !== 1'b0) begin n_fail++; $display("FAIL sleep_gate got %b exp 0", req_val_o[0]); end
    n_tests++; if (core_rst_no !== 2'b11) begin n_fail++; $display("FAIL park_rst_hold got %b exp 11", core_rst_no); end
    req_val_i = 2'b00;
  endtask

  task automatic test_park_wake_cancel;
    send_pkt(64'h0000_0000_0001_0001);
    req_val_i = 2'b01; req_ack_i = 2'b00;
    send_pkt(64'h0000_0000_0003_0000);
    n_tests++; if (hart_state_o !== 4'b1011) begin n_fail++; $display("FAIL cancel_drain got %b exp 1011", hart_state_o); end
    n_tests++; if (req_val_o[0] !== 1'b1) begin n_fail++; $display("FAIL cancel_hold got %b exp 1", req_val_o[0]); end
    send_pkt(64'h0000_0000_0001_0001);
    n_tests++; if (hart_state_o !== 4'b1010) begin n_fail++; $display("FAIL cancel_run got %b exp 1010", hart_state_o); end
    n_tests++; if (req_val_o[0] !== 1'b1) begin n_fail++; $display("FAIL cancel_no_drop got %b exp 1", req_val_o[0]); end
    req_ack_i = 2'b01; tick();
    req_ack_i = 2'b00; req_val_i = 2'b00; tick();
  endtask

  task automatic test_irq_sync;
    irq_async_i = 8'h20;
    tick();
    n_tests++; if (irq_sync_o[5] !== 1'b0) begin n_fail++; $display("FAIL irq_rise_c1 got %b exp 0", irq_sync_o[5]); end
    tick();
    n_tests++; if (irq_sync_o !== 8'h20) begin n_fail++; $display("FAIL irq_rise_c2 got %h exp 20", irq_sync_o); end
    irq_async_i = 8'h00;
    tick();
    n_tests++; if (irq_sync_o[5] !== 1'b1) begin n_fail++; $display("FAIL irq_fall_c1 got %b exp 1", irq_sync_o[5]); end
    tick();
    n_tests++; if (irq_sync_o[5] !== 1'b0) begin n_fail++; $display("FAIL irq_fall_c2 got %b exp 0", irq_sync_o[5]); end
  endtask

  task automatic test_broadcast_init;
    reset_l = 1'b0; tick();
    reset_l = 1'b1;
    tick(); tick();
    send_pkt(64'h0000_0000_0001_1F01);
    n_tests++; if (hart_state_o !== 4'b0000) begin n_fail++; $display("FAIL bcast_init_c3 got %b exp 0000", hart_state_o); end
    repeat (5) begin
      tick();
      n_tests++; if (hart_state_o !== 4'b0000) begin n_fail++; $display("FAIL bcast_no_sleep got %b exp 0000", hart_state_o); end
    end
    n_tests++; if (init_done_o !== 1'b1) begin n_fail++; $display("FAIL bcast_init_done got %b exp 1", init_done_o); end
    tick();
    n_tests++; if (hart_state_o !== 4'b1010) begin n_fail++; $display("FAIL bcast_run got %b exp 1010", hart_state_o); end
  endtask

  task automatic test_reset_mid_run;
    req_val_i = 2'b11; irq_async_i = 8'hFF;
    tick(); tick();
    n_tests++; if (core_rst_no !== 2'b11) begin n_fail++; $display("FAIL midrun_rst got %b exp 11", core_rst_no); end
    n_tests++; if (irq_sync_o !== 8'hFF) begin n_fail++; $display("FAIL midrun_irq got %h exp ff", irq_sync_o); end
    reset_l = 1'b0;
    tick();
    n_tests++; if (hart_state_o !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_state got %b exp 0000", hart_state_o); end
    n_tests++; if (req_val_o !== 2'b00) begin n_fail++; $display("FAIL rst_mid_req got %b exp 00", req_val_o); end
    n_tests++; if (core_rst_no !== 2'b00) begin n_fail++; $display("FAIL rst_mid_core got %b exp 00", core_rst_no); end
    n_tests++; if (irq_sync_o !== 8'h00) begin n_fail++; $display("FAIL rst_mid_irq got %h exp 00", irq_sync_o); end
    n_tests++; if (init_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b exp 0", init_done_o); end
  endtask

  initial begin
    test_reset();
    test_init_sleep();
    test_wake_hart1();
    test_park_drain();
    test_park_wake_cancel();
    test_irq_sync();
    test_broadcast_init();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piton_core_wakeup_ctrl.md
Name: piton_core_wakeup_ctrl

Overview:
- Per-tile core wakeup/park sequencer for up to NUM_HARTS cores sharing one L1.5 return path.
- Waits a fixed SRAM-init interval after reset, then decodes interrupt return packets to wake and park individual harts.
- Gates each hart's L1.5 request valid, holding it for an in-flight request, and drives a per-hart core reset.
- Also synchronises each hart's asynchronous interrupt lines.

Parameters:
NUM_HARTS, 1, number of independently controlled harts (1..32)
HART_ID_W, 5, width of the hart-select field in the interrupt packet (2^HART_ID_W > NUM_HARTS)
CNT_WIDTH, 16, init-wait counter width; init done when MSB sets, i.e. 2^(CNT_WIDTH-1) cycles after reset release
IRQ_WIDTH, 4, async interrupt lines per hart
SYNC_STAGES, 2, flop stages per interrupt synchroniser (>=2)

Ports:
clk_i  in  1  clock
reset_l  in  1  reset; synchronous, active-low
rtrn_val_i  in  1  L1.5 return valid
rtrn_is_int_i  in  1  return type is interrupt (L15_INT_RET)
rtrn_data_i  in  64  return data_0
req_val_i  in  NUM_HARTS  per-hart request valid from core
req_ack_i  in  NUM_HARTS  per-hart header ack from L1.5
req_val_o  out  NUM_HARTS  gated request valid to L1.5
core_rst_no  out  NUM_HARTS  per-hart core reset, active-low
irq_async_i  in  NUM_HARTS*IRQ_WIDTH  async interrupt lines
irq_sync_o  out  NUM_HARTS*IRQ_WIDTH  synchronised interrupt lines
hart_state_o  out  NUM_HARTS*2  per-hart FSM state (debug)
init_done_o  out  1  init interval elapsed

Behaviour:
- Reset (reset_l=0 at clk edge): counter=0; all FSMs INIT; inflight, pending_wake and started bits =0; all synchroniser flops =0; req_val_o=0, core_rst_no=0, irq_sync_o=0, init_done_o=0, hart_state_o=0.
- Counter: increments each cycle; saturates once MSB=1. init_done_o = MSB (registered, 1 after exactly 2^(CNT_WIDTH-1) cycles).
- Packet decode: valid int packet = rtrn_val_i & rtrn_is_int_i.
  - WAKE: data[17:16]=2'b01 and data[5:0]=6'b000001.
  - PARK: data[17:16]=2'b11.
  - Target hart = data[8 +: HART_ID_W]; all-ones = broadcast to all harts; other ids >= NUM_HARTS are ignored.
- Per-hart FSM (encodings):
  - INIT(00):
    - WAKE sets pending_wake.
    - PARK clears pending_wake.
    - When counter MSB=1: go to RUN if pending_wake, else SLEEP.
  - SLEEP(01): WAKE -> RUN next cycle; PARK ignored.
  - RUN(10):
    - PARK -> DRAIN if inflight_q or (req_val_i & ~req_ack_i) this cycle, else SLEEP.
    - WAKE ignored.
  - DRAIN(11):
    - WAKE -> RUN (park cancelled).
    - Otherwise -> SLEEP in the cycle after req_ack_i for the held request.
- Request gating (combinational from state):
  - RUN: req_val_o = req_val_i.
  - DRAIN: req_val_o = req_val_i & inflight_q.
  - INIT/SLEEP: req_val_o = 0.
  - inflight_q <= req_val_o & ~req_ack_i.
  - A request presented to L1.5 is never withdrawn before ack.
- Core reset:
  - started bit set on first entry to RUN; core_rst_no = started (registered).
  - core_rst_no rises one cycle after first RUN entry and stays high through later SLEEP/DRAIN until reset_l.
- Interrupt sync: SYNC_STAGES-flop chain per bit; latency exactly SYNC_STAGES cycles; no gating by FSM.
- Reset mid-operation: any state returns to INIT; counter restarts; an in-flight request is dropped (L1.5 is reset too).

Optional Feature:
WAKEUP_OVERRIDE_EN
- Defined: adds input wakeup_override_i [NUM_HARTS]. When high, a hart in SLEEP moves to RUN, and a hart in INIT goes to RUN at counter MSB, without needing a WAKE packet. PARK is still honoured but the hart re-enters RUN the next cycle while override remains high.
- Undefined: port absent; only WAKE packets leave SLEEP.

Test Plan:
- CNT_WIDTH=4, NUM_HARTS=2, no packets -> init_done_o=1 at cycle 8 after reset release; both hart_state_o=01; req_val_o=0 and core_rst_no=0 with req_val_i=2'b11.
- WAKE to hart 1 (data=64'h0001_0101) after init -> hart1 state 10 next cycle; core_rst_no[1]=1 the cycle after; req_val_o[1] follows req_val_i[1]; hart0 stays 01.
- WAKE broadcast (hart field 5'h1F) during INIT at cycle 3 -> both harts go INIT->RUN at cycle 8 with no intermediate SLEEP.
- Hart0 RUN with req_val_i=1, req_ack_i=0, then PARK -> state 11; req_val_o[0] held 1 until req_ack_i pulse; state 01 next cycle; core_rst_no[0] remains 1.
- PARK to hart0 then WAKE while still in DRAIN -> returns to 10; no req_val_o drop observed.
- Toggle irq_async_i bit 5 with SYNC_STAGES=2 -> irq_sync_o[5] follows after exactly 2 cycles; assert reset_l=0 mid-RUN -> next edge all outputs 0, states 00.
